mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 64, memory words addressed
- WIDTH, 4, data width in bits
- ADDR_WIDTH, $clog2(DEPTH), address width
- TIMEOUT, 8, maximum cycles valid_o waits for ready_i; legal range 2..255
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all logic is on its rising edge
- rst_i, in, 1, reset; synchronous, active-low
- cmd_valid_i, in, 1, command offered
- cmd_ready_o, out, 1, command accepted this cycle
- cmd_wr_i, in, 1, 1=write, 0=read
- cmd_addr_i, in, ADDR_WIDTH, command address
- cmd_wdata_i, in, WIDTH, command write data
- rsp_valid_o, out, 1, response available
- rsp_ready_i, in, 1, response consumed
- rsp_rdata_o, out, WIDTH, read data; 0 for writes and errors
- rsp_err_o, out, 1, transaction timed out
- valid_o, out, 1, memory request valid
- wr_rd_en_o, out, 1, 1=write, 0=read
- addr_o, out, ADDR_WIDTH, memory address
- w_data_o, out, WIDTH, memory write data
- rdata_i, in, WIDTH, memory read data, valid one cycle after the read handshake
- ready_i, in, 1, memory ready
- err_cnt_o, out, 8, saturating count of timed-out transactions

Function
REQ-003 FSM states SHALL be IDLE, REQ, RDATA and RESP; one transaction is in flight at a time.
REQ-004 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o, and the FSM then moves to REQ.
REQ-005 On acceptance, cmd_wr_i, cmd_addr_i and cmd_wdata_i SHALL be registered into wr_rd_en_o, addr_o and w_data_o; w_data_o SHALL be 0 for reads.
REQ-006 In REQ, valid_o SHALL be 1, and wr_rd_en_o, addr_o and w_data_o SHALL stay stable until the handshake or the timeout.
REQ-007 The handshake SHALL occur on the first REQ cycle with ready_i=1. Next state is RESP for a write and RDATA for a read.
REQ-008 valid_o SHALL be 0 in every state except REQ, so it deasserts in the cycle after the handshake.
REQ-009 RDATA SHALL last exactly one cycle: rdata_i is captured into rsp_rdata_o, and the next state is RESP.
REQ-010 A wait counter SHALL clear on entry to REQ and increment on each REQ cycle with ready_i=0.
REQ-011 When the counter reaches TIMEOUT with ready_i=0, the FSM SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0, and err_cnt_o SHALL increment, saturating at 255.
REQ-012 If ready_i=1 on the same cycle the timeout would fire, the handshake SHALL win and no error is reported.
REQ-013 In RESP, rsp_valid_o SHALL be 1, and rsp_rdata_o and rsp_err_o SHALL hold until rsp_ready_i=1; the FSM then returns to IDLE.
REQ-014 cmd_ready_o SHALL rise in the cycle after the response handshake. There is no command/response overlap.
REQ-015 Minimum latency SHALL be as follows, with ready_i=1 on the first REQ cycle:
- write: command accept to rsp_valid_o, 2 cycles
- read: command accept to rsp_valid_o, 3 cycles
REQ-016 All outputs SHALL be known (non-X) at every clock edge after the first reset cycle.
REQ-017 addr_o SHALL carry cmd_addr_i unmodified; out-of-range addresses (addr >= DEPTH) are passed through, not checked.

Reset
REQ-018 With rst_i=0 at a clock edge, the FSM SHALL go to IDLE and the following SHALL be 0: valid_o, wr_rd_en_o, addr_o, w_data_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, err_cnt_o and the wait counter.
REQ-019 cmd_ready_o SHALL be 0 while rst_i=0 and 1 from the first cycle with rst_i=1.
REQ-020 Reset asserted mid-transaction (REQ, RDATA or RESP) SHALL abandon the transaction, with no response and no err_cnt_o change, and valid_o=0 from the next edge.

Verification
REQ-021 Write: cmd wr=1, addr=5, wdata=0xA; ready_i=1 one cycle after valid_o -> valid_o high 2 cycles with addr_o=5 and w_data_o=0xA; then rsp_valid_o=1, rsp_err_o=0.
REQ-022 Read: cmd wr=0, addr=63; ready_i=1 on the first REQ cycle; rdata_i=0x7 on the next cycle -> rsp_rdata_o=0x7, rsp_err_o=0, 3-cycle latency.
REQ-023 Timeout: ready_i held 0 -> valid_o high exactly 8 cycles, then rsp_err_o=1, rsp_rdata_o=0, err_cnt_o=1.
REQ-024 Timeout tie: ready_i=1 on the 8th REQ cycle -> normal completion, rsp_err_o=0, err_cnt_o unchanged.
REQ-025 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data held 5 cycles, cmd_ready_o=0 throughout; cmd_ready_o=1 one cycle after rsp_ready_i=1.
REQ-026 Reset and saturation:
- rst_i=0 during REQ -> all outputs 0 next edge, no response
- 260 consecutive timeouts -> err_cnt_o=255

Source files
------------

// File: rtl/mem_master_if.sv
// mem_master_if: command/response handshake plus memory request bus.
interface mem_master_if #(
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 6
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_wr_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [WIDTH-1:0]      cmd_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [WIDTH-1:0]      rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  valid_o;
  logic                  wr_rd_en_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WIDTH-1:0]      w_data_o;
  logic [WIDTH-1:0]      rdata_i;
  logic                  ready_i;
  logic [7:0]            err_cnt_o;
  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i, rdata_i, ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, valid_o, wr_rd_en_o,
           addr_o, w_data_o, err_cnt_o
  );
  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i, rdata_i, ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, valid_o, wr_rd_en_o,
           addr_o, w_data_o, err_cnt_o
  );
endinterface

// File: rtl/mem_master.sv
// mem_master: single-outstanding memory master with request timeout and error count.
module mem_master #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_t;
  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       timeout;
  // a handshake on the last allowed cycle beats the timeout
  assign timeout         = state == REQ && !bus.ready_i && wait_cnt == 8'(TIMEOUT - 1);
  assign bus.cmd_ready_o = state == IDLE && rst_i;
  assign bus.valid_o     = state == REQ;
  assign bus.rsp_valid_o = state == RESP;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.cmd_valid_i ? REQ : IDLE;
      REQ:     state_nx = bus.ready_i ? (bus.wr_rd_en_o ? RESP : RDATA) : (timeout ? RESP : REQ);
      RDATA:   state_nx = RESP;
      RESP:    state_nx = bus.rsp_ready_i ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.wr_rd_en_o  <= 1'b0;
      bus.addr_o      <= '0;
      bus.w_data_o    <= '0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.err_cnt_o   <= 8'd0;
      wait_cnt        <= 8'd0;
    end else begin
      if (state == IDLE && bus.cmd_valid_i) begin
        bus.wr_rd_en_o <= bus.cmd_wr_i;
        bus.addr_o     <= bus.cmd_addr_i;
        bus.w_data_o   <= bus.cmd_wr_i ? bus.cmd_wdata_i : '0;
      end
      wait_cnt <= (state == REQ && !bus.ready_i) ? wait_cnt + 8'd1 : 8'd0;
      if (timeout && bus.err_cnt_o != 8'hff) bus.err_cnt_o <= bus.err_cnt_o + 8'd1;
      if (state == RDATA) begin
        bus.rsp_rdata_o <= bus.rdata_i;
      end else if (timeout) begin
        bus.rsp_rdata_o <= '0;
        bus.rsp_err_o   <= 1'b1;
      end else if (state == IDLE) begin
        bus.rsp_rdata_o <= '0;
        bus.rsp_err_o   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized stimulus with queued expectations checked by a negedge monitor.
module tb_mem_master;
  localparam int TIMEOUT = 8;
  typedef struct {logic wr; logic [5:0] addr; logic [3:0] wdata; int len;} req_t;
  typedef struct {logic [3:0] rdata; logic err; logic [7:0] cnt;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   live = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  int   exp_cnt = 0;
  logic [3:0] mem [64];
  req_t req_q[$];
  rsp_t rsp_q[$];
  mem_master_if #(.WIDTH(4), .ADDR_WIDTH(6)) bus ();
  mem_master #(.DEPTH(64), .WIDTH(4), .ADDR_WIDTH(6), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (live) begin
    chk("known", 32'($isunknown({bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o,
        bus.valid_o, bus.wr_rd_en_o, bus.addr_o, bus.w_data_o, bus.err_cnt_o})), 0);
    if (bus.valid_o) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        chk("req_wr", 32'(bus.wr_rd_en_o), 32'(req_q[0].wr));
        chk("req_addr", 32'(bus.addr_o), 32'(req_q[0].addr));
        chk("req_wdata", 32'(bus.w_data_o), 32'(req_q[0].wdata));
      end
      run++;
    end else if (run > 0) begin
      if (req_q.size() != 0) begin
        chk("req_len", run, req_q[0].len);
        void'(req_q.pop_front());
      end
      run = 0;
    end
    if (bus.rsp_valid_o) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        chk("rsp_rdata", 32'(bus.rsp_rdata_o), 32'(rsp_q[0].rdata));
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(rsp_q[0].err));
        chk("err_cnt", 32'(bus.err_cnt_o), 32'(rsp_q[0].cnt));
        if (bus.rsp_ready_i) void'(rsp_q.pop_front());
      end
    end
  end
  task automatic zero_check(input string name);
    chk(name, {bus.valid_o, bus.rsp_valid_o, bus.wr_rd_en_o, bus.addr_o, bus.w_data_o,
               bus.rsp_rdata_o, bus.rsp_err_o, bus.err_cnt_o, bus.cmd_ready_o}, 0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    zero_check("reset_outputs");
    live = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(bus.cmd_ready_o), 1);
  endtask
  task automatic accept(input bit wr, input logic [5:0] a, input logic [3:0] d);
    int n = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_wr_i = wr;
    bus.cmd_addr_i = a;
    bus.cmd_wdata_i = d;
    while (!bus.cmd_ready_o && n < 20) begin @(posedge clk); #1; n++; end
    chk("cmd_ready", 32'(bus.cmd_ready_o), 1);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wr_i = 1'($urandom);
    bus.cmd_addr_i = 6'($urandom);
    bus.cmd_wdata_i = 4'($urandom);
  endtask
  task automatic txn(input bit wr, input logic [5:0] a, input logic [3:0] d, input int dly, input int rdly);
    bit   to = dly >= TIMEOUT;
    int   lat, n;
    req_t rq;
    rsp_t rs;
    if (to) exp_cnt = exp_cnt == 255 ? 255 : exp_cnt + 1;
    rq.wr = wr; rq.addr = a; rq.wdata = wr ? d : 4'h0; rq.len = to ? TIMEOUT : dly + 1;
    rs.rdata = (wr || to) ? 4'h0 : mem[a]; rs.err = to; rs.cnt = 8'(exp_cnt);
    req_q.push_back(rq);
    rsp_q.push_back(rs);
    accept(wr, a, d);
    lat = 1;
    for (int k = 0; ; k++) begin
      bus.ready_i = k == dly;
      @(posedge clk); #1;
      lat++;
      if (k == dly || k == TIMEOUT - 1) break;
    end
    bus.ready_i = 1'b0;
    if (!wr && !to) begin
      bus.rdata_i = mem[a];
      @(posedge clk); #1;
      lat++;
      bus.rdata_i = 4'($urandom);
    end
    if (wr && !to) mem[a] = d;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin @(posedge clk); #1; lat++; n++; end
    chk("latency", lat, to ? TIMEOUT + 1 : (wr ? dly + 2 : dly + 3));
    for (int i = 0; i < rdly; i++) begin
      chk("backpressure_hold", {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b10);
      @(posedge clk); #1;
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk("cmd_ready_after_rsp", {bus.cmd_ready_o, bus.rsp_valid_o}, 2'b10);
  endtask
  task automatic abort_txn();
    req_t rq;
    rq.wr = 1'b1; rq.addr = 6'h2a; rq.wdata = 4'h5; rq.len = 3;
    req_q.push_back(rq);
    accept(1'b1, 6'h2a, 4'h5);
    bus.ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    zero_check("abort_outputs");
    rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_abort", 32'(bus.cmd_ready_o), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    int n = 0;
    for (int i = 0; i < 64; i++) mem[i] = 4'($urandom);
    mem[63] = 4'h7;
    bus.cmd_wr_i = 1'b0;
    bus.cmd_addr_i = '0;
    bus.cmd_wdata_i = '0;
    bus.rdata_i = '0;
    do_reset();
    txn(1'b1, 6'd5, 4'ha, 1, 0);
    txn(1'b0, 6'd63, 4'h0, 0, 0);
    do_reset();
    txn(1'b0, 6'd20, 4'h3, TIMEOUT, 0);
    txn(1'b1, 6'd9, 4'h3, TIMEOUT - 1, 0);
    txn(1'b0, 6'd5, 4'h0, 0, 5);
    abort_txn();
    for (int i = 0; i < 150; i++)
      txn(1'($urandom), 6'($urandom), 4'($urandom), $urandom_range(0, TIMEOUT + 1), $urandom_range(0, 3));
    for (int i = 0; i < 260; i++)
      txn(1'($urandom), 6'($urandom), 4'($urandom), TIMEOUT, 0);
    chk("err_cnt_saturated", 32'(bus.err_cnt_o), 255);
    while ((req_q.size() + rsp_q.size()) != 0 && n < 50) begin @(negedge clk); n++; end
    chk("queues_drained", req_q.size() + rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
